note_scheduler: RTL

- Sits between song_reader and the bank of note_player voices.
- Accepts each new_note (note, duration, advance flag) from song_reader and dispatches it to a free voice.
- Holds song time for the note's duration when its advance flag is set, then pulses note_done so song_reader fetches the next entry.
- Chord entries (advance=0) are dispatched back-to-back with no time gap, giving polyphony.

---
 rtl/note_scheduler_pkg.sv | 15 +
 rtl/note_scheduler_if.sv | 31 +++
 rtl/note_scheduler_voice_picker.sv | 29 ++
 rtl/note_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// Shared types and default widths for note_scheduler and song_reader.
// State encodings are fixed so checkers can decode state_dbg directly.
package note_sched_pkg;
    localparam int NUM_VOICES_DEF     = 3;
    localparam int NOTE_WIDTH_DEF     = 6;
    localparam int DURATION_WIDTH_DEF = 6;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        WAIT_NOTE = 3'b001,
        DISPATCH  = 3'b010,
        WAIT_TIME = 3'b011,
        REQUEST   = 3'b100
    } sched_state_e;
endpackage

// File: rtl/note_scheduler_if.sv
// Bundle of the song_reader-side and voice-side signals around note_scheduler.
// master = scheduler side, slave = song_reader / voice-bank side.
interface note_sched_if #(
    parameter int NUM_VOICES     = 3,
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6
) (
    input logic clk
);
    // new_note is a one-cycle pulse; note/duration/advance are valid only with it.
    // note_done is a one-cycle request for the next entry; song_reader keeps one note outstanding.
    logic                      new_note;
    logic [NOTE_WIDTH-1:0]     note;
    logic [DURATION_WIDTH-1:0] duration;
    logic                      advance;
    logic                      note_done;
    logic [NUM_VOICES-1:0]     voice_busy;
    logic [NUM_VOICES-1:0]     voice_load;
    logic [NOTE_WIDTH-1:0]     voice_note;
    logic [DURATION_WIDTH-1:0] voice_duration;
    logic                      overrun;

    modport master (
        input  clk, new_note, note, duration, advance, voice_busy,
        output note_done, voice_load, voice_note, voice_duration, overrun
    );
    modport slave (
        input  clk, note_done, voice_load, voice_note, voice_duration, overrun,
        output new_note, note, duration, advance, voice_busy
    );
endinterface

// File: rtl/note_scheduler_voice_picker.sv
// Combinational voice selection: lowest-index free voice, plus the
// round-robin steal target used when every voice is busy.
module voice_picker
    import note_sched_pkg::*;
#(
    parameter int  NUM_VOICES = NUM_VOICES_DEF,
    localparam int PTR_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0] voice_busy,
    input  logic [PTR_W-1:0]      rr_ptr,
    output logic [NUM_VOICES-1:0] free_oh,
    output logic                  any_free,
    output logic [NUM_VOICES-1:0] steal_oh
);
    localparam logic [NUM_VOICES-1:0] ONE = NUM_VOICES'(1);

    always_comb begin
        free_oh  = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!voice_busy[i] && !any_free) begin
                free_oh[i] = 1'b1;
                any_free   = 1'b1;
            end
        end
    end

    assign steal_oh = ONE << rr_ptr;
endmodule

// File: rtl/note_scheduler.sv
// Dispatches song_reader entries to free note_player voices and paces song time.
// Optional macro NOTE_SCHED_VOICE_STEAL_EN: steal the round-robin voice when all are busy.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int NUM_VOICES     = NUM_VOICES_DEF,
    parameter int NOTE_WIDTH     = NOTE_WIDTH_DEF,
    parameter int DURATION_WIDTH = DURATION_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      new_note,
    input  logic [NOTE_WIDTH-1:0]     note,
    input  logic [DURATION_WIDTH-1:0] duration,
    input  logic                      advance,
    input  logic [NUM_VOICES-1:0]     voice_busy,
    output logic                      note_done,
    output logic [NUM_VOICES-1:0]     voice_load,
    output logic [NOTE_WIDTH-1:0]     voice_note,
    output logic [DURATION_WIDTH-1:0] voice_duration,
    output logic                      overrun,
    output logic [2:0]                state_dbg
);
    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    sched_state_e              state_q, state_d;
    logic [DURATION_WIDTH-1:0] cnt_q, cnt_d;
    logic [NOTE_WIDTH-1:0]     note_q, note_d;
    logic [DURATION_WIDTH-1:0] dur_q, dur_d;
    logic                      adv_q, adv_d;
    logic [PTR_W-1:0]          rr_ptr;
    logic [NUM_VOICES-1:0]     free_oh, steal_oh;
    logic                      any_free;
    logic                      dispatch_go;

`ifdef NOTE_SCHED_VOICE_STEAL_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    assign rr_ptr = ptr_q;
`else
    logic unused_steal;
    assign rr_ptr       = '0;
    assign unused_steal = ^steal_oh;
`endif

    voice_picker #(.NUM_VOICES(NUM_VOICES)) u_picker (
        .voice_busy (voice_busy),
        .rr_ptr     (rr_ptr),
        .free_oh    (free_oh),
        .any_free   (any_free),
        .steal_oh   (steal_oh)
    );

    // Rests (note 0) still consume time but never touch a voice.
    assign dispatch_go = (state_q == DISPATCH) && play && (note_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        dur_d   = dur_q;
        adv_d   = adv_q;
`ifdef NOTE_SCHED_VOICE_STEAL_EN
        ptr_d   = ptr_q;
`endif
        if (state_q != IDLE && !play) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:      if (play) state_d = WAIT_NOTE;
                WAIT_NOTE: if (new_note) begin
                    note_d  = note;
                    dur_d   = duration;
                    adv_d   = advance;
                    state_d = DISPATCH;
                end
                DISPATCH: begin
                    if (adv_q && dur_q != '0) begin
                        state_d = WAIT_TIME;
                        cnt_d   = dur_q;
                    end else begin
                        state_d = REQUEST;
                    end
`ifdef NOTE_SCHED_VOICE_STEAL_EN
                    if (dispatch_go && !any_free)
                        ptr_d = (ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : ptr_q + PTR_W'(1);
`endif
                end
                WAIT_TIME: if (beat) begin
                    if (cnt_q == DURATION_WIDTH'(1)) begin
                        state_d = REQUEST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DURATION_WIDTH'(1);
                    end
                end
                REQUEST:   state_d = WAIT_NOTE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            adv_q   <= 1'b0;
`ifdef NOTE_SCHED_VOICE_STEAL_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            adv_q   <= adv_d;
`ifdef NOTE_SCHED_VOICE_STEAL_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        voice_load = '0;
        if (dispatch_go) begin
            if (any_free) voice_load = free_oh;
`ifdef NOTE_SCHED_VOICE_STEAL_EN
            else voice_load = steal_oh;
`endif
        end
    end

    assign overrun        = dispatch_go && !any_free;
    assign note_done      = (state_q == REQUEST) && play;
    assign voice_note     = note_q;
    assign voice_duration = dur_q;
    assign state_dbg      = state_q;
endmodule
